port_out_bank: RTL and testbench

- Parametrised bank of N_CH write-strobe-loaded output registers. Successor to the single 8-bit output-port data register.
- Sits between the soft-core processor I/O bus (port_id, write_strobe, read_strobe, out_port, in_port) and N_CH downstream consumers.
- Adds the following over the single register:
  - address decode;
  - per-channel valid/ack handshake;
  - sticky overrun detection;
  - registered status read-back.

---
 rtl/port_out_pkg.sv | 20 ++
 rtl/port_out_channel.sv | 60 ++++++
 rtl/port_out_bank.sv | 95 +++++++++
 tb/tb_port_out_bank.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_out_pkg.sv
// Shared constants and address helper for the port_out_bank output register bank.
package port_out_pkg;

  localparam int MAX_CH    = 8;
  localparam int OFS_VALID = 0;
  localparam int OFS_OVR   = 1;

  // Compare at aw bits so base+ofs wraps like the port_id bus does.
  function automatic logic addr_hit(
    input logic [31:0] pid,
    input logic [31:0] base,
    input logic [31:0] ofs,
    input int          aw
  );
    logic [31:0] m;
    m = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
    return ((base + ofs) & m) == (pid & m);
  endfunction

endpackage

// File: rtl/port_out_channel.sv
// One output channel: data register, valid/ack handshake, sticky overrun and load pulse.
module port_out_channel #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_hit_i,
  input  logic              ack_i,
  input  logic              ovr_clr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              load_o,
  output logic              ovr_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              load_q, load_d;
  logic              ovr_q, ovr_d;
  logic              take;
  logic              new_ovr;

  assign take    = ack_i & valid_q;
  assign new_ovr = wr_hit_i & valid_q & ~ack_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    load_d  = wr_hit_i;
    if (take)
      valid_d = 1'b0;
    if (wr_hit_i) begin
      data_d  = wdata_i;
      valid_d = 1'b1;
    end
    // A fresh overrun beats a same-cycle clear.
    ovr_d = new_ovr | (ovr_q & ~ovr_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      load_q  <= load_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign load_o  = load_q;
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/port_out_bank.sv
// Bank of N_CH write-strobe-loaded output channels with status read-back.
module port_out_bank
  import port_out_pkg::*;
#(
  parameter int               DATA_W    = 8,
  parameter int               N_CH      = 4,
  parameter int               ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int               STAT_OFS  = N_CH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      port_id,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic [DATA_W-1:0]      out_port,
  output logic [DATA_W-1:0]      in_port,
  input  logic                   en,
  output logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH-1:0]        ch_ack,
  output logic [N_CH-1:0]        ch_load
);

  if (N_CH < 1 || N_CH > MAX_CH || N_CH > DATA_W ||
      STAT_OFS < N_CH ||
      longint'(STAT_OFS) + 2 > (64'd1 << ADDR_W)) begin : g_bad_cfg
    $fatal(1, "port_out_bank: illegal N_CH/DATA_W/STAT_OFS/ADDR_W");
  end

  logic [N_CH-1:0]   wr_hit;
  logic [N_CH-1:0]   ch_hit;
  logic [N_CH-1:0]   ovr_clr;
  logic [N_CH-1:0]   ovr;
  logic              hit_valid;
  logic              hit_ovr;
  logic [DATA_W-1:0] in_port_q, in_port_d;
  logic [DATA_W-1:0] rd_sel;
  logic              wr_ok;

  assign wr_ok     = en & write_strobe;
  assign hit_valid = addr_hit(32'(port_id), 32'(BASE_ADDR),
                              32'(STAT_OFS + OFS_VALID), ADDR_W);
  assign hit_ovr   = addr_hit(32'(port_id), 32'(BASE_ADDR),
                              32'(STAT_OFS + OFS_OVR), ADDR_W);

  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < N_CH; i++)
      ch_hit[i] = addr_hit(32'(port_id), 32'(BASE_ADDR), 32'(i), ADDR_W);
  end

  assign wr_hit  = ch_hit & {N_CH{wr_ok}};
  assign ovr_clr = out_port[N_CH-1:0] & {N_CH{wr_ok & hit_ovr}};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    port_out_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_hit_i  (wr_hit[g]),
      .ack_i     (ch_ack[g]),
      .ovr_clr_i (ovr_clr[g]),
      .wdata_i   (out_port),
      .data_o    (ch_data[g*DATA_W +: DATA_W]),
      .valid_o   (ch_valid[g]),
      .load_o    (ch_load[g]),
      .ovr_o     (ovr[g])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (ch_hit[i])
        rd_sel = ch_data[i*DATA_W +: DATA_W];
    if (hit_valid)
      rd_sel[N_CH-1:0] = ch_valid;
    if (hit_ovr)
      rd_sel[N_CH-1:0] = ovr;
  end

  assign in_port_d = read_strobe ? rd_sel : in_port_q;

  always_ff @(posedge clk) begin
    if (rst)
      in_port_q <= '0;
    else
      in_port_q <= in_port_d;
  end

  assign in_port = in_port_q;

endmodule

// File: tb/tb_port_out_bank.sv
// Scoreboard bench for port_out_bank: stimulus queues expectations, a monitor compares.
module tb_port_out_bank;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int AW = 8;

  localparam logic [7:0] A_VAL = 8'h04;
  localparam logic [7:0] A_OVR = 8'h05;

  localparam int W_INP = 0;
  localparam int W_DAT = 1;
  localparam int W_VAL = 2;
  localparam int W_LD  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    port_id;
  logic             write_strobe;
  logic             read_strobe;
  logic [DW-1:0]    out_port;
  logic [DW-1:0]    in_port;
  logic             en;
  logic [NC*DW-1:0] ch_data;
  logic [NC-1:0]    ch_valid;
  logic [NC-1:0]    ch_ack;
  logic [NC-1:0]    ch_load;

  port_out_bank #(
    .DATA_W    (DW),
    .N_CH      (NC),
    .ADDR_W    (AW),
    .BASE_ADDR (8'h00),
    .STAT_OFS  (NC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .en           (en),
    .ch_data      (ch_data),
    .ch_valid     (ch_valid),
    .ch_ack       (ch_ack),
    .ch_load      (ch_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         what;
    int         ch;
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t sb[$];
  int    cnt = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [7:0] observe(int what, int ch);
    logic [7:0] v;
    v = '0;
    case (what)
      W_INP:   v = in_port;
      W_DAT:   v = ch_data[ch*DW +: DW];
      W_VAL:   v[NC-1:0] = ch_valid;
      default: v[NC-1:0] = ch_load;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cnt) begin
        logic [7:0] act;
        act = observe(sb[i].what, sb[i].ch);
        n_vec++;
        if (act !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s: got %02h want %02h", sb[i].name, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  function automatic void push(int c, int w, int ch, logic [7:0] e, string n);
    item_t it;
    it.cyc  = c;
    it.what = w;
    it.ch   = ch;
    it.exp  = e;
    it.name = n;
    sb.push_back(it);
  endfunction

  function automatic void chk(int w, int ch, logic [7:0] e, string n);
    push(cnt, w, ch, e, n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string n);
    port_id     = a;
    read_strobe = 1'b1;
    push(cnt + 1, W_INP, 0, e, n);
    tick();
    read_strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; port_id = '0; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = '0; en = 1'b1; ch_ack = '0;
    tick(); tick();
    rst = 1'b0;

    wr(8'h00, 8'hA5);
    chk(W_DAT, 0, 8'hA5, "pre_rst_data0");
    rd(8'h00, 8'hA5, "pre_rst_rd0");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(W_DAT, 0, 8'h00, "rst_data0");
    chk(W_VAL, 0, 8'h00, "rst_valid");
    chk(W_INP, 0, 8'h00, "rst_in_port");
    chk(W_LD,  0, 8'h00, "rst_load");
    rd(A_OVR, 8'h00, "rst_ovr");

    wr(8'h02, 8'h3C);
    chk(W_DAT, 2, 8'h3C, "load_data2");
    chk(W_VAL, 0, 8'h04, "load_valid");
    chk(W_LD,  0, 8'h04, "load_pulse");
    n_vec++;
    if (ch_data[2*DW +: DW] !== 8'h3C) begin
      n_err++;
      $display("FAIL d_load_data2: got %02h", ch_data[2*DW +: DW]);
    end
    tick();
    chk(W_LD,  0, 8'h00, "load_pulse_end");
    chk(W_VAL, 0, 8'h04, "valid_hold");
    ch_ack = 4'b0100;
    tick();
    ch_ack = '0;
    chk(W_VAL, 0, 8'h00, "ack_clear");
    chk(W_DAT, 2, 8'h3C, "ack_data_hold");

    wr(8'h01, 8'h11);
    wr(8'h01, 8'h22);
    chk(W_DAT, 1, 8'h22, "ovr_data1");
    n_vec++;
    if (ch_data[1*DW +: DW] !== 8'h22) begin
      n_err++;
      $display("FAIL d_ovr_data1: got %02h", ch_data[1*DW +: DW]);
    end
    rd(A_OVR, 8'h02, "ovr_set");
    wr(A_OVR, 8'h02);
    rd(A_OVR, 8'h00, "ovr_w1c");
    chk(W_VAL, 0, 8'h02, "ovr_valid1");

    wr(8'h03, 8'h44);
    port_id = 8'h03; out_port = 8'h55; write_strobe = 1'b1; ch_ack = 4'b1000;
    tick();
    write_strobe = 1'b0; ch_ack = '0;
    chk(W_DAT, 3, 8'h55, "wack_data3");
    chk(W_VAL, 0, 8'h0A, "wack_valid");
    n_vec++;
    if (ch_valid !== 4'b1010) begin
      n_err++;
      $display("FAIL d_wack_valid: got %01h", ch_valid);
    end
    rd(A_OVR, 8'h00, "wack_no_ovr");

    ch_ack = 4'b1111;
    tick();
    ch_ack = '0;
    chk(W_VAL, 0, 8'h00, "ack_all");
    wr(8'h00, 8'h5A);
    wr(8'h02, 8'hC3);
    rd(A_VAL, 8'h05, "rd_valid");
    rd(8'h40, 8'h00, "rd_unmapped");
    rd(8'h02, 8'hC3, "rd_ch2");
    tick();
    chk(W_INP, 0, 8'hC3, "in_port_hold");

    en = 1'b0;
    wr(8'h00, 8'h99);
    en = 1'b1;
    chk(W_DAT, 0, 8'h5A, "gate_data0");
    chk(W_LD,  0, 8'h00, "gate_no_load");
    n_vec++;
    if (ch_load !== 4'b0000) begin
      n_err++;
      $display("FAIL d_gate_no_load: got %01h", ch_load);
    end
    wr(A_VAL, 8'hFF);
    rd(A_VAL, 8'h05, "valid_ro");
    wr(8'h00, 8'h66);
    rd(A_OVR, 8'h01, "ovr0_set");
    en = 1'b0;
    wr(A_OVR, 8'h01);
    en = 1'b1;
    rd(A_OVR, 8'h01, "ovr_clr_gated");
    wr(A_OVR, 8'h01);
    rd(A_OVR, 8'h00, "ovr_clr_en");

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    foreach (sb[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got none want %02h", sb[i].name, sb[i].exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
